// File: rtl/pezaris_pkg.sv
// Shared types and constants for the Pezaris sequential multiplier.
package pezaris_pkg;

   // Widest operand the correction-constant helper can describe.
   localparam int unsigned MAX_WIDTH = 64;
   localparam int unsigned CORR_W    = 2 * MAX_WIDTH;

   // Controller states.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCUM   = 2'd1,
      RESOLVE = 2'd2,
      DONE    = 2'd3
   } state_e;

   // Per-bit cell type of the carry-save row: TYPE1 negates the partial-product input.
   typedef enum logic {
      CELL_TYPE0 = 1'b0,
      CELL_TYPE1 = 1'b1
   } cell_type_e;

   // Constant that restores the true value after negative-weight bits were inverted.
   // The inverted positions cover weights 2^(N-1)..2^(2N-3) twice, so the fix-up is
   // -(2^(2N-1) - 2^N) mod 2^(2N) = 2^(2N-1) + 2^N.
   function automatic logic [CORR_W-1:0] corr_const(input int unsigned width);
      return (CORR_W'(1) << (2 * width - 1)) | (CORR_W'(1) << width);
   endfunction

endpackage

// File: rtl/pezaris_csa_row.sv
// One row of full adders folding a partial-product row into a carry-save pair.
module pezaris_csa_row
   import pezaris_pkg::*;
#(
   parameter int unsigned W = 16
) (
   input  logic [W-1:0] sum_i,
   input  logic [W-1:0] carry_i,
   input  logic [W-1:0] pp_i,
   input  logic [W-1:0] cell_type_i,
   output logic [W-1:0] sum_c_o,
   output logic [W-1:0] carry_c_o
);

   logic [W-1:0] z;
   logic [W-1:0] maj;

   // Third adder input: TYPE1 cells see the complemented partial-product bit.
   always_comb begin
      z = '0;
      for (int i = 0; i < W; i++) begin
         z[i] = (cell_type_e'(cell_type_i[i]) == CELL_TYPE1) ? ~pp_i[i] : pp_i[i];
      end
   end

   // Full-adder sum and majority; carries move up one weight, the top one is dropped.
   assign sum_c_o   = sum_i ^ carry_i ^ z;
   assign maj       = (sum_i & carry_i) | (sum_i & z) | (carry_i & z);
   assign carry_c_o = maj << 1;

endmodule

// File: rtl/pezaris_seq_multiplier.sv
// Sequential Pezaris multiplier: one carry-save row per clock, then one carry-propagate add.
module pezaris_seq_multiplier
   import pezaris_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 tc,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy
);

   localparam int unsigned PW    = 2 * WIDTH;
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   localparam logic [PW-1:0]    CORR     = PW'(corr_const(WIDTH));
   localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);
   localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(WIDTH - 1);

   state_e             state_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic               tc_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [PW-1:0]      sum_q;
   logic [PW-1:0]      carry_q;
   logic [PW-1:0]      product_q;
   logic               in_ready_q;
   logic               out_valid_q;
   logic               busy_q;

   logic [WIDTH-1:0]   b_sh;
   logic               last_row;
   logic [WIDTH-1:0]   neg_cols;
   logic [PW-1:0]      pp_row;
   logic [PW-1:0]      cell_type;
   logic [PW-1:0]      sum_d;
   logic [PW-1:0]      carry_d;

   // Current partial-product row and its negative-weight mask, both aligned to weight 2^k.
   always_comb begin
      b_sh      = b_q >> cnt_q;
      last_row  = (cnt_q == LAST_ROW);
      neg_cols  = '0;
      if (tc_q) begin
         neg_cols = last_row ? ~MSB_MASK : MSB_MASK;
      end
      pp_row    = PW'(a_q & {WIDTH{b_sh[0]}}) << cnt_q;
      cell_type = PW'(neg_cols) << cnt_q;
   end

   pezaris_csa_row #(
      .W (PW)
   ) u_csa_row (
      .sum_i       (sum_q),
      .carry_i     (carry_q),
      .pp_i        (pp_row),
      .cell_type_i (cell_type),
      .sum_c_o     (sum_d),
      .carry_c_o   (carry_d)
   );

   // Controller, row counter, carry-save accumulators and final adder.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         tc_q        <= 1'b0;
         cnt_q       <= '0;
         sum_q       <= '0;
         carry_q     <= '0;
         product_q   <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  a_q        <= a;
                  b_q        <= b;
                  tc_q       <= tc;
                  cnt_q      <= '0;
                  sum_q      <= '0;
                  carry_q    <= '0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= ACCUM;
               end
            end
            ACCUM: begin
               sum_q   <= sum_d;
               carry_q <= carry_d;
               cnt_q   <= cnt_q + CNT_W'(1);
               if (last_row) begin
                  state_q <= RESOLVE;
               end
            end
            RESOLVE: begin
               product_q   <= sum_q + carry_q + (tc_q ? CORR : '0);
               out_valid_q <= 1'b1;
               state_q     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign product   = product_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_pezaris_seq_multiplier.sv
// Bench for pezaris_seq_multiplier at widths 8 (index 0), 4 (index 1) and 16 (index 2).
module tb_pezaris_seq_multiplier;

   logic        clk = 1'b0;
   logic        rst_n;

   logic [2:0]  iv_v;
   logic [2:0]  ordy_v;
   logic [2:0]  tc_v;
   logic [15:0] a_d [3];
   logic [15:0] b_d [3];

   logic [2:0]  ir_v;
   logic [2:0]  ov_v;
   logic [2:0]  busy_v;
   logic [15:0] prod8;
   logic [7:0]  prod4;
   logic [31:0] prod16;
   logic [31:0] prod_o [3];

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [15:0] DA  [7] = '{16'h80, 16'h7F, 16'hFF, 16'hFF, 16'hFF, 16'h00, 16'h80};
   localparam logic [15:0] DB  [7] = '{16'h80, 16'h80, 16'h01, 16'hFF, 16'hFF, 16'hA7, 16'h7F};
   localparam logic        DTC [7] = '{1'b1,   1'b1,   1'b1,   1'b0,   1'b1,   1'b1,   1'b0};
   localparam logic [31:0] DEX [7] = '{32'h4000, 32'hC080, 32'hFFFF, 32'hFE01, 32'h0001, 32'h0000, 32'h3F80};

   always #5 clk = ~clk;

   pezaris_seq_multiplier #(.WIDTH(8)) u_dut8 (
      .clk (clk), .rst_n (rst_n),
      .in_valid (iv_v[0]), .in_ready (ir_v[0]),
      .a (a_d[0][7:0]), .b (b_d[0][7:0]), .tc (tc_v[0]),
      .out_valid (ov_v[0]), .out_ready (ordy_v[0]),
      .product (prod8), .busy (busy_v[0])
   );

   pezaris_seq_multiplier #(.WIDTH(4)) u_dut4 (
      .clk (clk), .rst_n (rst_n),
      .in_valid (iv_v[1]), .in_ready (ir_v[1]),
      .a (a_d[1][3:0]), .b (b_d[1][3:0]), .tc (tc_v[1]),
      .out_valid (ov_v[1]), .out_ready (ordy_v[1]),
      .product (prod4), .busy (busy_v[1])
   );

   pezaris_seq_multiplier #(.WIDTH(16)) u_dut16 (
      .clk (clk), .rst_n (rst_n),
      .in_valid (iv_v[2]), .in_ready (ir_v[2]),
      .a (a_d[2]), .b (b_d[2]), .tc (tc_v[2]),
      .out_valid (ov_v[2]), .out_ready (ordy_v[2]),
      .product (prod16), .busy (busy_v[2])
   );

   assign prod_o[0] = 32'(prod8);
   assign prod_o[1] = 32'(prod4);
   assign prod_o[2] = prod16;

   function automatic int wid(input int sel);
      case (sel)
         0:       return 8;
         1:       return 4;
         default: return 16;
      endcase
   endfunction

   // Reference: interpret operands as signed or unsigned integers, multiply, keep 2N bits.
   function automatic logic [31:0] ref_mul(input int w, input logic [15:0] a, input logic [15:0] b,
                                           input logic tc);
      longint m, va, vb, p;
      m  = (longint'(1) << w) - 1;
      va = longint'(a) & m;
      vb = longint'(b) & m;
      if (tc) begin
         if (va >= (longint'(1) << (w - 1))) va = va - (longint'(1) << w);
         if (vb >= (longint'(1) << (w - 1))) vb = vb - (longint'(1) << w);
      end
      p = va * vb;
      return 32'(p & ((longint'(1) << (2 * w)) - 1));
   endfunction

   // Full transaction: accept, wait for the result, hand it off; reports product, latency, handshake health.
   task automatic do_op(input int sel, input logic [15:0] a, input logic [15:0] b, input logic tc,
                        input bit early_rdy, output logic [31:0] prod, output int lat, output bit hs_ok);
      int w;
      int n;
      w     = wid(sel);
      hs_ok = 1'b1;
      n     = 0;
      while (ir_v[sel] !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (ir_v[sel] !== 1'b1) hs_ok = 1'b0;
      iv_v[sel]   = 1'b1;
      a_d[sel]    = a;
      b_d[sel]    = b;
      tc_v[sel]   = tc;
      ordy_v[sel] = early_rdy;
      @(negedge clk);
      iv_v[sel] = 1'b0;
      a_d[sel]  = 16'($urandom);
      b_d[sel]  = 16'($urandom);
      tc_v[sel] = ~tc;
      lat = 0;
      while (ov_v[sel] !== 1'b1 && lat < w + 10) begin
         if (ir_v[sel] !== 1'b0 || busy_v[sel] !== 1'b1) hs_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      prod = prod_o[sel];
      if (ir_v[sel] !== 1'b0 || busy_v[sel] !== 1'b1) hs_ok = 1'b0;
      ordy_v[sel] = 1'b1;
      @(negedge clk);
      ordy_v[sel] = 1'b0;
      if (ov_v[sel] !== 1'b0 || ir_v[sel] !== 1'b1 || busy_v[sel] !== 1'b0 || prod_o[sel] !== prod)
         hs_ok = 1'b0;
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      iv_v   = '0;
      ordy_v = '0;
      tc_v   = '0;
      for (int i = 0; i < 3; i++) begin
         a_d[i] = '0;
         b_d[i] = '0;
      end
      repeat (3) @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         n_cmp++;
         if ({ir_v[s], ov_v[s], busy_v[s]} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_flags dut%0d: got ir/ov/busy=%b want 100", s, {ir_v[s], ov_v[s], busy_v[s]});
         end
         n_cmp++;
         if (prod_o[s] !== 32'h0) begin
            n_err++;
            $display("FAIL reset_product dut%0d: got %h want 0", s, prod_o[s]);
         end
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (ir_v !== 3'b111 || ov_v !== 3'b000) begin
         n_err++;
         $display("FAIL post_reset_idle: got ir=%b ov=%b want 111/000", ir_v, ov_v);
      end
   endtask

   task automatic test_directed();
      logic [31:0] p;
      int          lat;
      bit          ok;
      for (int i = 0; i < 7; i++) begin
         do_op(0, DA[i], DB[i], DTC[i], 1'b0, p, lat, ok);
         n_cmp++;
         if (p !== DEX[i]) begin
            n_err++;
            $display("FAIL directed_product[%0d] a=%h b=%h tc=%0d: got %h want %h", i, DA[i], DB[i], DTC[i], p, DEX[i]);
         end
         n_cmp++;
         if (lat !== 9) begin
            n_err++;
            $display("FAIL directed_latency[%0d]: got %0d edges want 9", i, lat);
         end
         n_cmp++;
         if (!ok) begin
            n_err++;
            $display("FAIL directed_handshake[%0d]: got bad ready/valid/busy sequence want clean", i);
         end
      end
   endtask

   task automatic test_backpressure();
      int n;
      @(negedge clk);
      iv_v[0] = 1'b1;
      a_d[0]  = 16'h80;
      b_d[0]  = 16'h80;
      tc_v[0] = 1'b1;
      @(negedge clk);
      iv_v[0] = 1'b0;
      n = 0;
      while (ov_v[0] !== 1'b1 && n < 30) begin
         @(negedge clk);
         n++;
      end
      n_cmp++;
      if (ov_v[0] !== 1'b1 || prod_o[0] !== 32'h4000) begin
         n_err++;
         $display("FAIL bp_result: got ov=%b prod=%h want 1/4000", ov_v[0], prod_o[0]);
      end
      for (int c = 0; c < 20; c++) begin
         iv_v[0] = 1'b1;
         a_d[0]  = 16'($urandom);
         b_d[0]  = 16'($urandom);
         tc_v[0] = 1'($urandom);
         @(negedge clk);
         n_cmp++;
         if (ov_v[0] !== 1'b1 || ir_v[0] !== 1'b0 || busy_v[0] !== 1'b1 || prod_o[0] !== 32'h4000) begin
            n_err++;
            $display("FAIL bp_hold cycle %0d: got ov=%b ir=%b busy=%b prod=%h want 1/0/1/4000",
                     c, ov_v[0], ir_v[0], busy_v[0], prod_o[0]);
         end
      end
      iv_v[0]   = 1'b0;
      ordy_v[0] = 1'b1;
      @(negedge clk);
      ordy_v[0] = 1'b0;
      n_cmp++;
      if (ov_v[0] !== 1'b0 || ir_v[0] !== 1'b1 || prod_o[0] !== 32'h4000) begin
         n_err++;
         $display("FAIL bp_release: got ov=%b ir=%b prod=%h want 0/1/4000", ov_v[0], ir_v[0], prod_o[0]);
      end
      @(negedge clk);
      n_cmp++;
      if (busy_v[0] !== 1'b0 || ov_v[0] !== 1'b0) begin
         n_err++;
         $display("FAIL bp_idle: got busy=%b ov=%b want 0/0", busy_v[0], ov_v[0]);
      end
   endtask

   task automatic test_reset_mid_op();
      logic [31:0] p;
      int          lat;
      bit          ok;
      bit          stale;
      @(negedge clk);
      iv_v[0] = 1'b1;
      a_d[0]  = 16'h5A;
      b_d[0]  = 16'h3C;
      tc_v[0] = 1'b0;
      @(negedge clk);
      iv_v[0] = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (ov_v[0] !== 1'b0 || ir_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || prod_o[0] !== 32'h0) begin
         n_err++;
         $display("FAIL midreset_clear: got ov=%b ir=%b busy=%b prod=%h want 0/1/0/0",
                  ov_v[0], ir_v[0], busy_v[0], prod_o[0]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      stale = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (ov_v[0] !== 1'b0 || busy_v[0] !== 1'b0) stale = 1'b1;
      end
      n_cmp++;
      if (stale) begin
         n_err++;
         $display("FAIL midreset_no_stale: got activity after release want none");
      end
      do_op(0, 16'h03, 16'hFB, 1'b1, 1'b0, p, lat, ok);
      n_cmp++;
      if (p !== 32'hFFF1 || lat !== 9 || !ok) begin
         n_err++;
         $display("FAIL midreset_next_op: got prod=%h lat=%0d ok=%0d want FFF1/9/1", p, lat, ok);
      end
   endtask

   task automatic test_sweep(input int sel, input int count, input bit exhaustive);
      logic [31:0] p;
      logic [31:0] exp;
      logic [15:0] a;
      logic [15:0] b;
      logic        tc;
      int          lat;
      int          w;
      bit          ok;
      w = wid(sel);
      for (int i = 0; i < count; i++) begin
         if (exhaustive) begin
            a  = 16'(i & 15);
            b  = 16'((i >> 4) & 15);
            tc = 1'(i >> 8);
         end else begin
            a  = 16'($urandom);
            b  = 16'($urandom);
            tc = 1'($urandom);
         end
         exp = ref_mul(w, a, b, tc);
         do_op(sel, a, b, tc, 1'($urandom), p, lat, ok);
         n_cmp++;
         if (p !== exp) begin
            n_err++;
            $display("FAIL sweep_w%0d_product a=%h b=%h tc=%0d: got %h want %h", w, a, b, tc, p, exp);
         end
         n_cmp++;
         if (lat !== w + 1 || !ok) begin
            n_err++;
            $display("FAIL sweep_w%0d_timing a=%h b=%h: got lat=%0d ok=%0d want %0d/1", w, a, b, lat, ok, w + 1);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid_op();
      test_sweep(1, 512, 1'b1);
      test_sweep(0, 300, 1'b0);
      test_sweep(2, 1000, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
